// File: rtl/counter_pkg.sv
// counter_pkg: shared state encoding and default width for the countdown timer
package counter_pkg;
    localparam int DEFAULT_BIT_SZ = 16;
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/countdown_timer_16.sv
// countdown_timer_16: loadable down-counter with start/stop, enable gating and terminal-count pulse
// Define AUTO_RELOAD_EN to compile in the reload register (periodic mode); default build is one-shot.
module countdown_timer_16
    import counter_pkg::*;
#(
    parameter int BIT_SZ = DEFAULT_BIT_SZ
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [BIT_SZ-1:0] load_value,
    input  logic              start,
    input  logic              stop,
    output logic [BIT_SZ-1:0] count,
    output logic              busy,
    output logic              tc
);
    state_t            state, state_nx;
    logic [BIT_SZ-1:0] count_nx;
    logic              tc_nx;

`ifdef AUTO_RELOAD_EN
    logic [BIT_SZ-1:0] reload;

    // reload value tracks every load so terminal count can restart from it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) reload <= '0;
        else if (load) reload <= load_value;
    end
`endif

    // command resolution: load > stop > start > decrement
    always_comb begin
        state_nx = state;
        count_nx = count;
        tc_nx    = 1'b0;
        if (load) begin
            count_nx = load_value;
            state_nx = IDLE;
        end else if (stop) begin
            state_nx = IDLE;
        end else if (start && state == IDLE) begin
            state_nx = (count != '0) ? RUN : IDLE;
        end else if (state == RUN && enable) begin
            if (count > BIT_SZ'(1)) begin
                count_nx = count - BIT_SZ'(1);
            end else if (count == BIT_SZ'(1)) begin
                tc_nx = 1'b1;
`ifdef AUTO_RELOAD_EN
                count_nx = reload;
                state_nx = (reload != '0) ? RUN : IDLE;
`else
                count_nx = '0;
                state_nx = IDLE;
`endif
            end
        end
    end

    // state, count and tc registers; reset aborts any run without a tc pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            tc    <= tc_nx;
        end
    end

    assign busy = (state == RUN);
endmodule

// File: doc/countdown_timer_16.md
COUNTDOWN_TIMER_16 -- requirements
Module: countdown_timer_16

Interface
REQ-001 The block SHALL have parameter BIT_SZ, default 16, setting the counter width.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: count qualifier; decrement occurs only when high.
REQ-005 The block SHALL have port load, input, 1 bit: one-cycle strobe that loads load_value into count.
REQ-006 The block SHALL have port load_value, input, BIT_SZ bits: value captured on load.
REQ-007 The block SHALL have port start, input, 1 bit: one-cycle strobe that begins counting down.
REQ-008 The block SHALL have port stop, input, 1 bit: one-cycle strobe that halts counting, holding count.
REQ-009 The block SHALL have port count, output, BIT_SZ bits: current counter value, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.

Function
REQ-012 The block SHALL implement two states: IDLE and RUN; busy = (state == RUN).
REQ-013 The per-edge command priority SHALL be load > stop > start > decrement.
REQ-014 On load in any state: count <= load_value, state <= IDLE, tc <= 0, with no decrement that cycle.
REQ-015 On stop without load: state <= IDLE, count held, tc <= 0.
REQ-016 On start in IDLE with count != 0 and no load or stop: state <= RUN; no decrement that cycle.
REQ-017 On start in IDLE with count == 0: the command is ignored, state stays IDLE, and tc stays 0.
REQ-018 On start while in RUN: the command is ignored.
REQ-019 In RUN with enable=1 and count > 1: count <= count - 1, tc <= 0.
REQ-020 In RUN with enable=1 and count == 1: count <= 0 and tc <= 1 for exactly one cycle, with the terminal action of REQ-030/031.
REQ-021 In RUN with enable=0: count and state hold, and tc <= 0.
REQ-022 In IDLE, count SHALL hold regardless of enable.
REQ-023 The count SHALL never wrap below 0; underflow is impossible by construction.
REQ-024 tc SHALL be asserted only in the cycle immediately after the 1->0 (or reload) transition, and SHALL be 0 otherwise.
REQ-025 Latency from a start edge to the first decrement edge SHALL be 1 cycle when enable is held high.

Reset
REQ-026 When reset is low, the block SHALL immediately, without waiting for a clock edge, force count = 0, state = IDLE, busy = 0, tc = 0, and reload register = 0.
REQ-027 Reset asserted mid-RUN SHALL abort counting with no tc pulse.
REQ-028 After reset is released, the block SHALL remain in IDLE until a load and then a start are received.

Configuration
REQ-029 The macro AUTO_RELOAD_EN SHALL select whether auto-reload is compiled in.
REQ-030 With AUTO_RELOAD_EN defined:
- a BIT_SZ reload register SHALL capture load_value on every load;
- at terminal count (REQ-020), count <= reload register (if the reload register is non-zero), tc pulses, and state stays RUN;
- if the reload register is 0, count <= 0 and state <= IDLE.
REQ-031 Without AUTO_RELOAD_EN: no reload register SHALL exist, and at terminal count state <= IDLE (one-shot).

Structure
REQ-032 A shared package counter_pkg SHALL hold the state enumeration (IDLE, RUN) and the default width constant of 16.
REQ-033 The block SHALL be one flat module with no sub-module, comprising a state register, count register, optional reload register, and tc register.

Verification
REQ-034 One-shot: reset; load 5; start; enable=1 -> count 5,4,3,2,1,0 on successive edges; tc high for exactly 1 cycle when count becomes 0; busy falls in that same cycle.
REQ-035 Enable gating: load 3; start; toggle enable 1,0,1,1 -> count 3,2,2,1,0; tc pulses once.
REQ-036 Priorities:
- load 9 and stop in the same cycle during RUN -> count = 9, IDLE.
- start with count = 0 -> stays IDLE, tc = 0.
REQ-037 Reset mid-run: load 0xFFFF; start; run 10 cycles; drive reset low between clock edges -> count = 0 and busy = 0 immediately; no tc pulse.
REQ-038 Auto-reload (AUTO_RELOAD_EN): load 2; start -> count 2,1,2,1,2 with tc pulse each reload and busy held high; stop -> IDLE with count held.
REQ-039 Width: with BIT_SZ=4, load 15; start; 15 enabled cycles -> count reaches 0 exactly once with no wrap to 15 (one-shot build).
